// File: rtl/lse_reduce_ctrl.sv
// lse_reduce_ctrl: reduces a stream of log-domain operands to a single value
// by repeated log-sum-exp accumulation through an external combinational
// LSE unit. Owns the accumulator, the beat bookkeeping and both handshakes.
module lse_reduce_ctrl #(
   parameter int unsigned        p_width    = 16,
   parameter int unsigned        p_len_bits = 8,
   parameter logic [p_width-1:0] p_neg_inf  = 16'h4000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [p_len_bits-1:0] i_len,
   input  logic                  i_abort,
   output logic                  o_busy,
   input  logic                  i_data_valid,
   input  logic [p_width-1:0]    i_data,
   output logic                  o_data_ready,
   output logic [p_width-1:0]    o_lse_a,
   output logic [p_width-1:0]    o_lse_b,
   input  logic [p_width-1:0]    i_lse_sum,
   output logic [p_width-1:0]    o_result,
   output logic                  o_result_valid,
   input  logic                  i_result_ready,
   output logic [p_len_bits-1:0] o_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [p_len_bits-1:0] c_one = p_len_bits'(1);

   state_t                  state_q, state_d;
   logic [p_width-1:0]      acc_q, acc_d;
   logic [p_len_bits-1:0]   rem_q, rem_d;
   logic [p_len_bits-1:0]   count_q, count_d;
   logic                    beat;

   // Handshake strobes come from registered state only, so neither ready
   // nor valid depends combinationally on the partner's signals.
   assign o_data_ready   = (state_q == ST_ACCUM);
   assign o_result_valid = (state_q == ST_DONE);
   assign o_busy         = (state_q == ST_ACCUM) || (state_q == ST_DONE);
   assign beat           = i_data_valid && o_data_ready;

   // The LSE unit always sees the accumulator and the raw incoming operand.
   assign o_lse_a  = acc_q;
   assign o_lse_b  = i_data;
   assign o_result = acc_q;
   assign o_count  = count_q;

   // Next-state and datapath update; abort overrides every other action.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               acc_d   = p_neg_inf;
               rem_d   = i_len;
               count_d = '0;
               // An empty job skips straight to DONE and returns log 0.
               state_d = (i_len != '0) ? ST_ACCUM : ST_DONE;
            end
         end
         ST_ACCUM: begin
            if (beat) begin
               acc_d   = i_lse_sum;
               rem_d   = rem_q - c_one;
               count_d = count_q + c_one;
               // Leaving at remaining==1 keeps the counter from underflowing.
               if (rem_q == c_one) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (i_result_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (i_abort) begin
         // Cancel drops any same-cycle beat; the beat count is kept for debug.
         state_d = ST_IDLE;
         acc_d   = p_neg_inf;
         rem_d   = rem_q;
         count_d = count_q;
      end
   end

   // State, accumulator and counters, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= p_neg_inf;
         rem_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_lse_reduce_ctrl.sv
// Bench for lse_reduce_ctrl: table of jobs with a scoreboard of expected
// results, plus hand-written abort and asynchronous-reset sequences.
module tb_lse_reduce_ctrl;

   localparam logic [15:0] NEG_INF = 16'h4000;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [7:0]  i_len;
   logic        i_abort;
   logic        o_busy;
   logic        i_data_valid;
   logic [15:0] i_data;
   logic        o_data_ready;
   logic [15:0] o_lse_a;
   logic [15:0] o_lse_b;
   logic [15:0] i_lse_sum;
   logic [15:0] o_result;
   logic        o_result_valid;
   logic        i_result_ready;
   logic [7:0]  o_count;

   int total;
   int bad;

   logic [23:0] sb[$];

   typedef struct packed {
      logic [7:0]       len;
      logic [3:0][15:0] ops;
      logic [3:0]       gap;
      logic [3:0]       bp;
      logic [15:0]      exp_res;
      logic [7:0]       exp_cnt;
   } vec_t;

   vec_t vecs[6];

   lse_reduce_ctrl dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (i_start),
      .i_len          (i_len),
      .i_abort        (i_abort),
      .o_busy         (o_busy),
      .i_data_valid   (i_data_valid),
      .i_data         (i_data),
      .o_data_ready   (o_data_ready),
      .o_lse_a        (o_lse_a),
      .o_lse_b        (o_lse_b),
      .i_lse_sum      (i_lse_sum),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .i_result_ready (i_result_ready),
      .o_count        (o_count)
   );

   // Stand-in LSE unit: log 0 is the identity, otherwise add magnitudes.
   function automatic logic [15:0] lse_model(input logic [15:0] a, input logic [15:0] b);
      logic [14:0] m;
      if (a == NEG_INF) return b;
      if (b == NEG_INF) return a;
      m = a[14:0] + b[14:0];
      return {1'b0, m};
   endfunction

   assign i_lse_sum = lse_model(o_lse_a, o_lse_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] len, input logic [15:0] o0, input logic [15:0] o1,
                               input logic [15:0] o2, input logic [15:0] o3, input logic [3:0] gap,
                               input logic [3:0] bp, input logic [15:0] res, input logic [7:0] cnt);
      vec_t v;
      v.len     = len;
      v.ops[0]  = o0;
      v.ops[1]  = o1;
      v.ops[2]  = o2;
      v.ops[3]  = o3;
      v.gap     = gap;
      v.bp      = bp;
      v.exp_res = res;
      v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic run_job(input vec_t v);
      logic [15:0] exp_acc;
      logic [15:0] held;
      logic [23:0] exp;
      int          w;
      @(negedge clk);
      i_start = 1'b1;
      i_len   = v.len;
      sb.push_back({v.exp_res, v.exp_cnt});
      @(negedge clk);
      i_start = 1'b0;
      chk("busy_after_start", o_busy, 1);
      chk("count_cleared", o_count, 0);
      exp_acc = NEG_INF;
      for (int k = 0; k < int'(v.len); k++) begin
         if (v.gap[k]) begin
            i_data_valid = 1'b0;
            chk("ready_in_gap", o_data_ready, 1);
            @(negedge clk);
         end
         chk("lse_a", o_lse_a, exp_acc);
         i_data       = v.ops[k];
         i_data_valid = 1'b1;
         @(negedge clk);
         exp_acc = lse_model(exp_acc, v.ops[k]);
      end
      i_data_valid = 1'b0;
      i_data       = 16'h0;
      chk("ready_in_done", o_data_ready, 0);
      w = 0;
      while (!o_result_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("result_latency", w, 0);
      held = o_result;
      for (int b = 0; b < int'(v.bp); b++) begin
         i_start = 1'b1;
         i_len   = 8'd5;
         chk("bp_valid", o_result_valid, 1);
         chk("bp_result", o_result, held);
         chk("bp_ready", o_data_ready, 0);
         @(negedge clk);
      end
      i_start        = 1'b0;
      i_result_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         exp = sb.pop_front();
         chk("valid_at_accept", o_result_valid, 1);
         chk("result", o_result, exp[23:8]);
         chk("count", o_count, exp[7:0]);
      end
      @(negedge clk);
      i_result_ready = 1'b0;
      chk("idle_after_accept", o_result_valid, 0);
      chk("busy_idle", o_busy, 0);
      chk("acc_hold_idle", o_result, exp[23:8]);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst_n          = 1'b1;
      i_start        = 1'b0;
      i_len          = 8'd0;
      i_abort        = 1'b0;
      i_data_valid   = 1'b0;
      i_data         = 16'h0;
      i_result_ready = 1'b0;

      vecs[0] = mk(8'd1, 16'h0123, 16'h0, 16'h0, 16'h0, 4'b0000, 4'd0, 16'h0123, 8'd1);
      vecs[1] = mk(8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 4'd0, 16'h4000, 8'd0);
      vecs[2] = mk(8'd3, 16'h0010, 16'h0020, 16'h0030, 16'h0, 4'b0110, 4'd0, 16'h0060, 8'd3);
      vecs[3] = mk(8'd4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b0000, 4'd5, 16'h000a, 8'd4);
      vecs[4] = mk(8'd2, 16'h1234, 16'h0111, 16'h0, 16'h0, 4'b0010, 4'd0, 16'h1345, 8'd2);
      vecs[5] = mk(8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 4'd2, 16'h4000, 8'd0);

      #2 rst_n = 1'b0;
      #1;
      chk("rst_lse_a", o_lse_a, 16'h4000);
      chk("rst_result", o_result, 16'h4000);
      chk("rst_count", o_count, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_data_ready, 0);
      chk("rst_valid", o_result_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i]);
      end

      // Abort on the second beat of a four-operand job.
      @(negedge clk);
      i_start = 1'b1;
      i_len   = 8'd4;
      @(negedge clk);
      i_start      = 1'b0;
      i_data       = 16'h0005;
      i_data_valid = 1'b1;
      @(negedge clk);
      chk("abort_pre_count", o_count, 1);
      chk("abort_pre_lse_a", o_lse_a, 16'h0005);
      i_data       = 16'h0006;
      i_abort      = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      i_abort      = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_valid", o_result_valid, 0);
      chk("abort_count", o_count, 1);
      chk("abort_lse_a", o_lse_a, 16'h4000);
      chk("abort_ready", o_data_ready, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_result", o_result_valid, 0);
      end

      // Asynchronous reset in the middle of accumulation.
      @(negedge clk);
      i_start = 1'b1;
      i_len   = 8'd3;
      @(negedge clk);
      i_start      = 1'b0;
      i_data       = 16'h0042;
      i_data_valid = 1'b1;
      @(negedge clk);
      i_data_valid = 1'b0;
      chk("mid_count", o_count, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_lse_a", o_lse_a, 16'h4000);
      chk("arst_result", o_result, 16'h4000);
      chk("arst_count", o_count, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_ready", o_data_ready, 0);
      chk("arst_valid", o_result_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job(mk(8'd2, 16'h0100, 16'h0200, 16'h0, 16'h0, 4'b0000, 4'd0, 16'h0300, 8'd2));

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lse_reduce_ctrl.md
# lse_reduce_ctrl

Sequencer that reduces a stream of log-domain operands (sign + 15-bit fixed-point magnitude, 16 bits total) to one value by repeated log-sum-exp accumulation. It owns the accumulator register and drives one external combinational LSE accumulate unit, one add per cycle. It sits between an operand producer (valid/ready) and a result consumer (valid/ready). Each job is a length-N reduction started by a one-cycle command.

## Interface
- p_width, 16, operand/accumulator width (sign bit + magnitude)
- p_len_bits, 8, width of job length and beat counter
- p_neg_inf, 16'h4000, log-domain zero code; accumulator seed and empty-job result

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  job start pulse; sampled only in IDLE
- i_len  in  p_len_bits  operand count for the job, sampled with i_start
- i_abort  in  1  synchronous job cancel, any state
- o_busy  out  1  high in ACCUM and DONE
- i_data_valid  in  1  operand valid
- i_data  in  p_width  operand
- o_data_ready  out  1  operand ready
- o_lse_a  out  p_width  accumulator value to the LSE unit (registered)
- o_lse_b  out  p_width  operand to the LSE unit (= i_data, combinational)
- i_lse_sum  in  p_width  LSE unit result for (o_lse_a, o_lse_b)
- o_result  out  p_width  reduction result
- o_result_valid  out  1  result valid
- i_result_ready  in  1  result consumer ready
- o_count  out  p_len_bits  beats accepted in the current or last job

## Operation
- State machine: IDLE, ACCUM, DONE.
- IDLE:
  - o_data_ready=0, o_result_valid=0.
  - i_start with i_len!=0: acc<=p_neg_inf, remaining<=i_len, o_count<=0; next state ACCUM.
  - i_start with i_len==0: acc<=p_neg_inf, o_count<=0; next state DONE. Empty reduction returns log 0.
- ACCUM:
  - o_data_ready=1.
  - Beat = i_data_valid & o_data_ready.
  - On a beat: acc<=i_lse_sum, remaining<=remaining-1, o_count<=o_count+1.
  - A beat with remaining==1 moves to DONE.
  - No beat: hold all state. Gaps in i_data_valid are legal.
- DONE:
  - o_result_valid=1, o_result=acc. Result is stable until accepted.
  - i_result_ready moves to IDLE. acc and o_count hold.
- o_lse_a is always the acc register.
- i_start outside IDLE is ignored. i_len is not re-sampled.
- i_abort (any state) moves to IDLE next cycle. acc<=p_neg_inf, no result is produced, o_count holds.
  - Abort has priority over a same-cycle beat, start, or result handshake. That beat is not consumed and the bench must not count it.
- Arithmetic is done entirely by the external unit. The controller never modifies i_lse_sum. remaining never underflows because DONE is entered at 1.
- Back-to-back jobs need one IDLE cycle between result acceptance and the next i_start.

## Timing
- Reset (async assert, any state) gives:
  - state IDLE, acc=p_neg_inf, so o_lse_a=o_result=16'h4000
  - o_count=0, remaining=0
  - o_busy=0, o_data_ready=0, o_result_valid=0
- Reset release is synchronous to i_clk. The first i_start is honored on the first rising edge after deassertion.
- Throughput: one operand per cycle in ACCUM.
- Latency:
  - o_result_valid rises the cycle after the last beat.
  - For a len=0 job, it rises the cycle after i_start.
- The LSE unit path (o_lse_a, i_data → i_lse_sum → acc) is single-cycle combinational. No internal pipeline.
- o_data_ready and o_result_valid are decoded from registered state only, with no combinational path from i_data_valid or i_result_ready.

## Test plan
- Reset, then i_start with i_len=1, and i_data=16'h0123 is valid the cycle after start; the bench LSE model returns b when a==16'h4000 → o_result=16'h0123, o_result_valid rises the next cycle, o_count=1.
- i_start with i_len=0 → o_data_ready stays 0, o_result_valid=1 the next cycle with o_result=16'h4000, o_count=0.
- i_len=3, operands 16'h0010, 16'h0020, 16'h0030 with valid gaps, bench model sum=a+b on the magnitude field:
  - o_lse_a sequence is 16'h4000, 16'h0010, 16'h0030
  - o_result=16'h0060 after exactly 3 beats
- Result backpressure: i_result_ready held low 5 cycles in DONE → o_result and o_result_valid stay stable, o_data_ready=0, and i_start is ignored.
- i_abort asserted together with the 2nd beat of an i_len=4 job → IDLE next cycle, no o_result_valid, o_count=1, o_lse_a=16'h4000.
- Asynchronous i_rst_n assertion mid-ACCUM (between clock edges) → all outputs take their reset values immediately. After release, a fresh i_len=2 job completes correctly.
